// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_pkg                                                         |
// | Purpose  : Shared types and helpers for the native-bus memory responder.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } mem_req_t;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;

  // 33-bit offset so a span reaching 2^32 and addresses below base both resolve correctly
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr >= base) && (off < span);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_be                                                         |
// | Purpose  : Single-port 32-bit RAM, byte enables, synchronous read, no reset.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_responder                                                   |
// | Purpose  : Bounded-latency RAM answering the core's mem_valid/mem_ready bus.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        fault
);

  localparam int          c_AW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  mem_state_t r_state;
  mem_req_t   r_req;
  logic [3:0] r_cnt;
  logic       r_rd_ok;

  logic            w_fault;
  logic            w_write;
  logic            w_mem_we;
  logic            w_mem_re;
  logic [c_AW-1:0] w_idx;
  logic [31:0]     w_sram_q;

  assign w_idx    = c_AW'((r_req.addr - BASE_ADDR) >> 2);
  assign w_write  = (r_req.wstrb != WSTRB_NONE);
  assign w_fault  = !addr_in_range(r_req.addr, BASE_ADDR, c_SPAN) || (r_req.instr && w_write);
  // RAM is touched only in RESP, so a reset during WAIT drops the store entirely
  assign w_mem_we = (r_state == RESP) && w_write && !w_fault;
  assign w_mem_re = (r_state == RESP) && !w_write && !w_fault;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_cnt     <= 4'd0;
      r_rd_ok   <= 1'b0;
      mem_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      fault     <= 1'b0;
      r_rd_ok   <= 1'b0;
      case (r_state)
        IDLE: begin
          // mem_valid is still high on the edge that sees mem_ready; do not re-accept it
          if (mem_valid && !mem_ready) begin
            r_req   <= '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr};
            r_cnt   <= c_LAT_M1;
            r_state <= (LATENCY > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          mem_ready <= 1'b1;
          fault     <= w_fault;
          r_rd_ok   <= w_mem_re;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_be    (r_req.wstrb),
    .i_re    (w_mem_re),
    .i_addr  (w_idx),
    .i_wdata (r_req.wdata),
    .o_rdata (w_sram_q)
  );

  assign mem_rdata = r_rd_ok ? w_sram_q : 32'h0;

  a_ready_single: assert property (@(posedge clk) disable iff (!reset_n) mem_ready |=> !mem_ready);
  a_fault_ready:  assert property (@(posedge clk) disable iff (!reset_n) fault |-> mem_ready);

endmodule
`default_nettype wire
